regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: register address width; NUM_REGS = 2**ADDR_W (derived, not overridable).
REQ-003 Parameter NR, default 2: number of read ports, range 1..4.
REQ-004 Parameter NW, default 1: number of write ports, range 1..2.
REQ-005 Parameter ZERO_REG, default 1: 1 = register 0 hardwired to zero.
REQ-006 Parameter INIT_IDX, default 1: 1 = reset loads register i with value i; 0 = reset loads zero.
REQ-007 clk  in  1  single clock; all state updates on posedge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 rd_addr  in  NR*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-010 rd_data  out  NR*DATA_W  read data, combinational, same packing.
REQ-011 rd_busy  out  NR  per read port: the addressed register has a pending write.
REQ-012 wr_en  in  NW  per-port write enable.
REQ-013 wr_addr  in  NW*ADDR_W  write addresses.
REQ-014 wr_data  in  NW*DATA_W  write data.
REQ-015 sb_set  in  1  issue strobe: mark sb_addr as pending-write.
REQ-016 sb_addr  in  ADDR_W  destination register of the issued instruction.
REQ-017 dbg_addr  in  ADDR_W  debug tap address.
REQ-018 dbg_data  out  DATA_W  debug tap data, registered.
REQ-019 busy_vec  out  NUM_REGS  full scoreboard, bit r = register r pending.

Function
REQ-020 Write: at posedge, each port k with wr_en[k]=1 updates reg[wr_addr[k]]; when ZERO_REG=1, writes to address 0 are dropped.
REQ-021 Write collision: two ports writing the same address in one cycle; port 1 wins.
REQ-022 Read: rd_data[i] is combinational from the array with zero added latency.
REQ-023 Bypass: if any enabled write port targets rd_addr[i] in the current cycle, rd_data[i] is that port's wr_data (port 1 wins per REQ-021); otherwise the array value.
REQ-024 With ZERO_REG=1, reads of address 0 return 0 regardless of bypass.
REQ-025 Scoreboard set: at posedge, sb_set=1 sets busy[sb_addr]; ignored for address 0 when ZERO_REG=1.
REQ-026 Scoreboard clear: at posedge, any enabled write to address r clears busy[r].
REQ-027 Simultaneous set and clear of the same address: set wins; busy stays 1.
REQ-028 rd_busy[i] = busy[rd_addr[i]] AND NOT bypass-hit on port i.
REQ-029 dbg_data loads at each posedge the bypassed read value of dbg_addr (equal to array contents after that edge's writes); 1-cycle latency.

Reset
REQ-030 rst_n low immediately, without waiting for clk: reg[i] = i truncated to DATA_W when INIT_IDX=1, else 0; reg[0] = 0 when ZERO_REG=1.
REQ-031 rst_n low: busy_vec = 0, rd_busy = 0, dbg_data = 0.
REQ-032 Writes or sets presented in the cycle rst_n deasserts are lost; the first update takes effect on the first posedge with rst_n high.

Structure
REQ-033 Shared package regfile_pkg holds default DATA_W, ADDR_W, NR and NW constants and the regfile address type.
REQ-034 Scoreboard (REQ-025..REQ-028) is sub-module regfile_scoreboard; storage, bypass and debug tap are implemented in regfile_mp.

Verification
REQ-035 Reset with INIT_IDX=1, read addresses 5 and 31 -> rd_data = 5 and 31; busy_vec = 0.
REQ-036 Write 0xDEADBEEF to r4 with rd_addr[0]=4 in the same cycle -> rd_data[0] = 0xDEADBEEF before the edge; array holds it after; dbg_addr=4 -> dbg_data = 0xDEADBEEF one cycle later.
REQ-037 Write 0x1234 to r0 -> rd_data = 0 for address 0; sb_set with sb_addr=0 -> busy_vec[0] stays 0.
REQ-038 NW=2, both ports write r7, data 0xAA and 0xBB -> r7 = 0xBB; bypassed read returns 0xBB.
REQ-039 sb_set r9 -> busy_vec[9]=1, rd_busy=1 when r9 is read; in the same cycle, sb_set r9 plus write r9 -> stays 1; next cycle write r9 alone -> cleared; rd_busy=0 during the bypass cycle.
REQ-040 rst_n low mid-run, asynchronously between edges, after r3 = 0x55 -> r3 = 3 and busy_vec = 0 immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-ported register file and its scoreboard.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NR     = 2;
    localparam int DEF_NW     = 1;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: issue marks a register busy, any enabled write to it clears it.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NW       = DEF_NW,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    input  logic [NW-1:0]            wr_en,
    input  logic [NW*ADDR_W-1:0]     wr_addr,
    output logic [(1<<ADDR_W)-1:0]   busy_vec
);

    logic [(1<<ADDR_W)-1:0] busy_next;

    // Clears are applied first so an issue to the same register in the same cycle wins.
    always_comb begin
        busy_next = busy_vec;
        for (int k = 0; k < NW; k++) begin
            if (wr_en[k]) begin
                busy_next[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (sb_set && !(ZERO_REG != 0 && sb_addr == '0)) begin
            busy_next[sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_next;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with write-to-read bypass, pending-write scoreboard
// and a registered debug tap.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NR       = DEF_NR,
    parameter int NW       = DEF_NW,
    parameter int ZERO_REG = 1,
    parameter int INIT_IDX = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NR*ADDR_W-1:0]     rd_addr,
    output logic [NR*DATA_W-1:0]     rd_data,
    output logic [NR-1:0]            rd_busy,
    input  logic [NW-1:0]            wr_en,
    input  logic [NW*ADDR_W-1:0]     wr_addr,
    input  logic [NW*DATA_W-1:0]     wr_data,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    output logic [(1<<ADDR_W)-1:0]   busy_vec
);

    localparam int NUM_REGS = 1 << ADDR_W;
    // Lookup ports: the NR read ports plus the debug tap as the last entry.
    localparam int NL = NR + 1;

    logic [DATA_W-1:0] regs      [NUM_REGS];
    logic [ADDR_W-1:0] look_addr [NL];
    logic [DATA_W-1:0] look_data [NL];
    logic [NL-1:0]     look_hit;

    for (genvar i = 0; i < NR; i++) begin : g_rd
        assign look_addr[i]                 = rd_addr[i*ADDR_W +: ADDR_W];
        assign rd_data[i*DATA_W +: DATA_W]  = look_data[i];
        assign rd_busy[i]                   = busy_vec[look_addr[i]] & ~look_hit[i];
    end
    assign look_addr[NR] = dbg_addr;

    // Higher-numbered write ports are scanned last so they win a same-address collision.
    always_comb begin
        look_data = '{default: '0};
        look_hit  = '0;
        for (int j = 0; j < NL; j++) begin
            look_data[j] = regs[look_addr[j]];
            for (int k = 0; k < NW; k++) begin
                if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] == look_addr[j]) begin
                    look_data[j] = wr_data[k*DATA_W +: DATA_W];
                    look_hit[j]  = 1'b1;
                end
            end
            if (ZERO_REG != 0 && look_addr[j] == '0) begin
                look_data[j] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= (INIT_IDX != 0 && !(ZERO_REG != 0 && r == 0)) ? DATA_W'(r) : '0;
            end
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (wr_en[k] && !(ZERO_REG != 0 && wr_addr[k*ADDR_W +: ADDR_W] == '0)) begin
                    regs[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // The bypassed lookup equals the array contents right after this edge's writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_data <= '0;
        end else begin
            dbg_data <= look_data[NR];
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NW       (NW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (NR=2, NW=2): driver pushes hand-computed expectations,
// a negedge monitor pops and compares them.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NR     = 2;
    localparam int NW     = 2;

    localparam int SIG_RD0   = 0;
    localparam int SIG_RD1   = 1;
    localparam int SIG_BUSY0 = 2;
    localparam int SIG_BUSY1 = 3;
    localparam int SIG_BVEC  = 4;
    localparam int SIG_DBG   = 5;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NR*ADDR_W-1:0]   rd_addr;
    logic [NR*DATA_W-1:0]   rd_data;
    logic [NR-1:0]          rd_busy;
    logic [NW-1:0]          wr_en;
    logic [NW*ADDR_W-1:0]   wr_addr;
    logic [NW*DATA_W-1:0]   wr_data;
    logic                   sb_set;
    reg_addr_t              sb_addr;
    reg_addr_t              dbg_addr;
    logic [DATA_W-1:0]      dbg_data;
    logic [31:0]            busy_vec;

    logic [31:0] exp_q[$];
    int          sig_q[$];
    int          checks = 0;
    int          errors = 0;

    regfile_mp #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NR       (NR),
        .NW       (NW),
        .ZERO_REG (1),
        .INIT_IDX (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .busy_vec (busy_vec)
    );

    // Clock and reset
    always #5 clk = ~clk;

    function automatic logic [31:0] sample(int s);
        case (s)
            SIG_RD0:   return rd_data[31:0];
            SIG_RD1:   return rd_data[63:32];
            SIG_BUSY0: return {31'd0, rd_busy[0]};
            SIG_BUSY1: return {31'd0, rd_busy[1]};
            SIG_BVEC:  return busy_vec;
            default:   return dbg_data;
        endcase
    endfunction

    function automatic string sig_name(int s);
        case (s)
            SIG_RD0:   return "rd_data0";
            SIG_RD1:   return "rd_data1";
            SIG_BUSY0: return "rd_busy0";
            SIG_BUSY1: return "rd_busy1";
            SIG_BVEC:  return "busy_vec";
            default:   return "dbg_data";
        endcase
    endfunction

    // Driver tasks
    task automatic push_exp(int s, logic [31:0] v);
        sig_q.push_back(s);
        exp_q.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        wr_en  = '0;
        sb_set = 1'b0;
    endtask

    task automatic rd(int i, int a);
        rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic wr(int k, int a, logic [31:0] d);
        wr_en[k]                    = 1'b1;
        wr_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
        wr_data[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic issue(int a);
        sb_set  = 1'b1;
        sb_addr = reg_addr_t'(a);
    endtask

    // Scoreboard monitor: outputs are settled at the falling edge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            logic [31:0] a;
            int          s;
            e = exp_q.pop_front();
            s = sig_q.pop_front();
            a = sample(s);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s actual=%h expected=%h t=%0t", sig_name(s), a, e, $time);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        sb_set   = 1'b0;
        sb_addr  = '0;
        dbg_addr = '0;
        rd(0, 5);
        rd(1, 31);
        push_exp(SIG_RD0, 32'd5);
        push_exp(SIG_RD1, 32'd31);
        push_exp(SIG_BVEC, 32'd0);
        push_exp(SIG_DBG, 32'd0);
        push_exp(SIG_BUSY0, 32'd0);
        step();
        step();
        // C0: release reset, reset contents visible
        rst_n = 1'b1;
        push_exp(SIG_RD0, 32'd5);
        push_exp(SIG_RD1, 32'd31);
        // C1: write r4 with same-cycle read of r4 (bypass)
        step();
        wr(0, 4, 32'hDEAD_BEEF);
        rd(0, 4);
        rd(1, 4);
        dbg_addr = 5'd4;
        push_exp(SIG_RD0, 32'hDEAD_BEEF);
        push_exp(SIG_RD1, 32'hDEAD_BEEF);
        push_exp(SIG_BUSY0, 32'd0);
        // C2: array holds it, debug tap one cycle later
        step();
        dbg_addr = 5'd5;
        push_exp(SIG_RD0, 32'hDEAD_BEEF);
        push_exp(SIG_DBG, 32'hDEAD_BEEF);
        // C3: write/issue to r0 are dropped
        step();
        push_exp(SIG_DBG, 32'd5);
        wr(0, 0, 32'h1234);
        issue(0);
        rd(1, 0);
        dbg_addr = 5'd0;
        push_exp(SIG_RD1, 32'd0);
        // C4
        step();
        push_exp(SIG_RD1, 32'd0);
        push_exp(SIG_BVEC, 32'd0);
        push_exp(SIG_DBG, 32'd0);
        // C5: both ports write r7, port 1 wins
        step();
        wr(0, 7, 32'hAA);
        wr(1, 7, 32'hBB);
        rd(0, 7);
        dbg_addr = 5'd7;
        push_exp(SIG_RD0, 32'hBB);
        // C6: array r7, plus two ports to different registers
        step();
        push_exp(SIG_RD0, 32'hBB);
        push_exp(SIG_DBG, 32'hBB);
        wr(0, 10, 32'h10A);
        wr(1, 11, 32'h11B);
        rd(1, 10);
        push_exp(SIG_RD1, 32'h10A);
        // C7
        step();
        rd(0, 10);
        rd(1, 11);
        push_exp(SIG_RD0, 32'h10A);
        push_exp(SIG_RD1, 32'h11B);
        push_exp(SIG_DBG, 32'hBB);
        // C8: issue r9
        step();
        issue(9);
        rd(0, 9);
        push_exp(SIG_RD0, 32'd9);
        push_exp(SIG_BUSY0, 32'd0);
        // C9: r9 pending
        step();
        rd(1, 9);
        push_exp(SIG_BVEC, 32'h0000_0200);
        push_exp(SIG_BUSY0, 32'd1);
        push_exp(SIG_BUSY1, 32'd1);
        // C10: issue and write r9 together, set wins
        step();
        issue(9);
        wr(0, 9, 32'h99);
        push_exp(SIG_RD0, 32'h99);
        push_exp(SIG_BUSY0, 32'd0);
        push_exp(SIG_BVEC, 32'h0000_0200);
        // C11: write r9 alone
        step();
        push_exp(SIG_BVEC, 32'h0000_0200);
        wr(0, 9, 32'h9A);
        rd(1, 8);
        push_exp(SIG_RD0, 32'h9A);
        push_exp(SIG_BUSY0, 32'd0);
        push_exp(SIG_RD1, 32'd8);
        push_exp(SIG_BUSY1, 32'd0);
        // C12: cleared; issue r20
        step();
        push_exp(SIG_BVEC, 32'd0);
        push_exp(SIG_RD0, 32'h9A);
        push_exp(SIG_BUSY0, 32'd0);
        issue(20);
        // C13
        step();
        rd(1, 20);
        push_exp(SIG_BVEC, 32'h0010_0000);
        push_exp(SIG_BUSY1, 32'd1);
        push_exp(SIG_RD1, 32'd20);
        // C14: port 1 write clears
        step();
        wr(1, 20, 32'h2020);
        push_exp(SIG_BUSY1, 32'd0);
        push_exp(SIG_RD1, 32'h2020);
        push_exp(SIG_BVEC, 32'h0010_0000);
        // C15: r3 = 0x55, issue r13
        step();
        push_exp(SIG_BVEC, 32'd0);
        wr(0, 3, 32'h55);
        issue(13);
        // C16
        step();
        rd(0, 3);
        rd(1, 4);
        push_exp(SIG_RD0, 32'h55);
        push_exp(SIG_RD1, 32'hDEAD_BEEF);
        push_exp(SIG_BVEC, 32'h0000_2000);
        // C17: asynchronous reset between edges
        step();
        rst_n = 1'b0;
        #1;
        push_exp(SIG_RD0, 32'd3);
        push_exp(SIG_RD1, 32'd4);
        push_exp(SIG_BVEC, 32'd0);
        push_exp(SIG_DBG, 32'd0);
        push_exp(SIG_BUSY0, 32'd0);
        step();
        rst_n = 1'b1;
        for (int n = 0; n < 5 && exp_q.size() > 0; n++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
